ddr_sref_sequencer: RTL and testbench

- Sequences DDR4 self-refresh entry and exit for the three host-side MIG channels (C0, C2, C3) around partial reconfiguration of the memory region.
- Drives the per-channel 8-bit DDR_SREF_CTRL_OUT buses, the MIG_x_RST_N resets and RESET_GATE.
- Watches the DDR_SREF_CTRL_IN status buses.
- Sits between the shell's AXI-Lite control register block, which issues single enter/exit commands, and the MIG/SREF wrappers.

---
 rtl/ddr_sref_pkg.sv | 37 +++
 rtl/ddr_sref_sequencer_if.sv | 25 ++
 rtl/sref_sync.sv | 25 ++
 rtl/ddr_sref_sequencer.sv | 240 ++++++++++++++++++++++++
 tb/tb_ddr_sref_sequencer.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ddr_sref_pkg.sv
// Shared constants for the DDR4 self-refresh sequencer: FSM encodings, error codes
// and bit positions inside each channel's 8-bit SREF control/status byte.
package ddr_sref_pkg;

   typedef logic [3:0] state_t;

   localparam state_t ST_IDLE      = 4'd0;
   localparam state_t ST_ENTER_REQ = 4'd1;
   localparam state_t ST_GATE      = 4'd2;
   localparam state_t ST_PARKED    = 4'd3;
   localparam state_t ST_RELEASE   = 4'd4;
   localparam state_t ST_WAIT_CAL  = 4'd5;
   localparam state_t ST_SREF_EXIT = 4'd6;
   localparam state_t ST_FAULT     = 4'd7;

   localparam logic [1:0] ERR_NONE     = 2'd0;
   localparam logic [1:0] ERR_ILLEGAL  = 2'd1;
   localparam logic [1:0] ERR_ENTER_TO = 2'd2;
   localparam logic [1:0] ERR_CAL_TO   = 2'd3;

   localparam logic OP_ENTER = 1'b1;
   localparam logic OP_EXIT  = 1'b0;

   localparam int SREF_REQ   = 0;
   localparam int RESTORE_EN = 1;
   localparam int ACK        = 0;
   localparam int CAL        = 1;

   function automatic logic accepts_cmd(input state_t st);
      return (st == ST_IDLE) || (st == ST_PARKED);
   endfunction

   function automatic logic is_busy(input state_t st);
      return !((st == ST_IDLE) || (st == ST_PARKED) || (st == ST_FAULT));
   endfunction

endpackage

// File: rtl/ddr_sref_sequencer_if.sv
// Command/status bundle between the shell control registers and the SREF sequencer.
interface ddr_sref_sequencer_if #(
   parameter int N_CH = 3
);
   logic            cmd_valid;
   logic            cmd_ready;
   logic            cmd_op;
   logic [N_CH-1:0] cmd_mask;
   logic            busy;
   logic [N_CH-1:0] in_sref;
   logic            done_pulse;
   logic            err_pulse;
   logic [1:0]      err_code;
   logic [3:0]      state_o;

   modport master (
      output cmd_valid, cmd_op, cmd_mask,
      input  cmd_ready, busy, in_sref, done_pulse, err_pulse, err_code, state_o
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_mask,
      output cmd_ready, busy, in_sref, done_pulse, err_pulse, err_code, state_o
   );
endinterface

// File: rtl/sref_sync.sv
// Plain two-flop synchroniser for the MIG status bits, cleared by the async reset.
module sref_sync #(
   parameter int WIDTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   logic [WIDTH-1:0] meta_r;
   logic [WIDTH-1:0] sync_r;

   // Two-stage capture of asynchronous status inputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_r <= {WIDTH{1'b0}};
         sync_r <= {WIDTH{1'b0}};
      end else begin
         meta_r <= d;
         sync_r <= meta_r;
      end
   end

   assign q = sync_r;
endmodule

// File: rtl/ddr_sref_sequencer.sv
// Sequences DDR4 self-refresh entry/exit and MIG reset isolation around partial
// reconfiguration for up to N_CH host-side memory channels.
module ddr_sref_sequencer
   import ddr_sref_pkg::*;
#(
   parameter int N_CH            = 3,
   parameter int RST_HOLD_CYCLES = 16,
   parameter int TIMEOUT_CYCLES  = 1000000,
   parameter int CNT_W           = 20
) (
   input  logic                sys_clk,
   input  logic                sys_rst_n,
   ddr_sref_sequencer_if.slave ctrl,
   input  logic [8*N_CH-1:0]   sref_ctrl_in,
   output logic [8*N_CH-1:0]   sref_ctrl_out,
   output logic [N_CH-1:0]     mig_rst_n,
   output logic                reset_gate
);
   localparam logic [CNT_W-1:0] TIMEOUT_C   = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] HOLD_LAST_C = CNT_W'(RST_HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE_C   = CNT_W'(1);
   localparam logic [N_CH-1:0]  NONE_C      = {N_CH{1'b0}};
   localparam logic [N_CH-1:0]  ALL_C       = {N_CH{1'b1}};

   logic [2*N_CH-1:0] raw_s;
   logic [2*N_CH-1:0] synced_s;
   logic [6*N_CH-1:0] unused_in_s;
   logic [N_CH-1:0]   ack_s;
   logic [N_CH-1:0]   cal_s;

   state_t            state_r;
   logic [N_CH-1:0]   m_r;
   logic [N_CH-1:0]   req_r;
   logic [N_CH-1:0]   rest_r;
   logic [N_CH-1:0]   mig_rst_r;
   logic              gate_r;
   logic [N_CH-1:0]   in_sref_r;
   logic              done_r;
   logic              err_r;
   logic [1:0]        code_r;
   logic              cmd_ready_r;
   logic              busy_r;
   logic [CNT_W-1:0]  cnt_r;

   state_t            state_nxt_s;
   logic [N_CH-1:0]   m_nxt_s;
   logic [N_CH-1:0]   req_nxt_s;
   logic [N_CH-1:0]   rest_nxt_s;
   logic [N_CH-1:0]   rst_nxt_s;
   logic              gate_nxt_s;
   logic [N_CH-1:0]   in_sref_nxt_s;
   logic              done_nxt_s;
   logic              err_nxt_s;
   logic [1:0]        code_nxt_s;

   logic              accept_s;
   logic [N_CH-1:0]   eff_mask_s;
   logic              illegal_s;
   logic              all_ack_s;
   logic              no_ack_s;
   logic              all_cal_s;
   logic              timeout_s;
   logic              hold_done_s;
   logic [N_CH-1:0]   left_s;

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      assign raw_s[2*i +: 2]                 = sref_ctrl_in[8*i +: 2];
      assign unused_in_s[6*i +: 6]           = sref_ctrl_in[8*i+2 +: 6];
      assign ack_s[i]                        = synced_s[2*i+ACK];
      assign cal_s[i]                        = synced_s[2*i+CAL];
      assign sref_ctrl_out[8*i+SREF_REQ]     = req_r[i];
      assign sref_ctrl_out[8*i+RESTORE_EN]   = rest_r[i];
      assign sref_ctrl_out[8*i+2 +: 6]       = 6'b000000;
   end

   sref_sync #(.WIDTH(2*N_CH)) u_sync (
      .clk   (sys_clk),
      .rst_n (sys_rst_n),
      .d     (raw_s),
      .q     (synced_s)
   );

   // On EXIT only channels actually parked count; an empty effective mask is rejected
   assign accept_s    = ctrl.cmd_valid & cmd_ready_r;
   assign eff_mask_s  = (state_r == ST_PARKED) ? (ctrl.cmd_mask & in_sref_r) : ctrl.cmd_mask;
   assign illegal_s   = (eff_mask_s == NONE_C)
                     || ((ctrl.cmd_op == OP_ENTER) && (state_r == ST_PARKED))
                     || ((ctrl.cmd_op == OP_EXIT)  && (state_r == ST_IDLE));
   assign all_ack_s   = ((ack_s & m_r) == m_r);
   assign no_ack_s    = ((ack_s & m_r) == NONE_C);
   assign all_cal_s   = ((cal_s & m_r) == m_r);
   assign timeout_s   = (cnt_r == TIMEOUT_C);
   assign hold_done_s = (cnt_r == HOLD_LAST_C);
   assign left_s      = in_sref_r & ~m_r;

   // Next-state and next-output decode; completion conditions are tested before timeouts
   always_comb begin
      state_nxt_s   = state_r;
      m_nxt_s       = m_r;
      req_nxt_s     = req_r;
      rest_nxt_s    = rest_r;
      rst_nxt_s     = mig_rst_r;
      gate_nxt_s    = gate_r;
      in_sref_nxt_s = in_sref_r;
      done_nxt_s    = 1'b0;
      err_nxt_s     = 1'b0;
      code_nxt_s    = code_r;
      case (state_r)
         ST_IDLE, ST_PARKED: begin
            if (accept_s) begin
               if (illegal_s) begin
                  err_nxt_s  = 1'b1;
                  code_nxt_s = ERR_ILLEGAL;
               end else if (ctrl.cmd_op == OP_ENTER) begin
                  code_nxt_s  = ERR_NONE;
                  m_nxt_s     = eff_mask_s;
                  req_nxt_s   = req_r | eff_mask_s;
                  state_nxt_s = ST_ENTER_REQ;
               end else begin
                  code_nxt_s  = ERR_NONE;
                  m_nxt_s     = eff_mask_s;
                  rest_nxt_s  = rest_r | eff_mask_s;
                  rst_nxt_s   = mig_rst_r | eff_mask_s;
                  state_nxt_s = ST_RELEASE;
               end
            end else begin
               state_nxt_s = state_r;
            end
         end
         ST_ENTER_REQ: begin
            if (all_ack_s) begin
               gate_nxt_s  = 1'b1;
               rst_nxt_s   = mig_rst_r & ~m_r;
               state_nxt_s = ST_GATE;
            end else if (timeout_s) begin
               req_nxt_s   = req_r & ~m_r;
               err_nxt_s   = 1'b1;
               code_nxt_s  = ERR_ENTER_TO;
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_ENTER_REQ;
            end
         end
         ST_GATE: begin
            if (hold_done_s) begin
               in_sref_nxt_s = in_sref_r | m_r;
               done_nxt_s    = 1'b1;
               state_nxt_s   = ST_PARKED;
            end else begin
               state_nxt_s = ST_GATE;
            end
         end
         ST_RELEASE: begin
            gate_nxt_s  = 1'b0;
            state_nxt_s = ST_WAIT_CAL;
         end
         ST_WAIT_CAL: begin
            if (all_cal_s) begin
               req_nxt_s   = req_r & ~m_r;
               rest_nxt_s  = rest_r & ~m_r;
               state_nxt_s = ST_SREF_EXIT;
            end else if (timeout_s) begin
               err_nxt_s   = 1'b1;
               code_nxt_s  = ERR_CAL_TO;
               state_nxt_s = ST_FAULT;
            end else begin
               state_nxt_s = ST_WAIT_CAL;
            end
         end
         ST_SREF_EXIT: begin
            if (no_ack_s) begin
               in_sref_nxt_s = left_s;
               done_nxt_s    = 1'b1;
               state_nxt_s   = (left_s == NONE_C) ? ST_IDLE : ST_PARKED;
            end else if (timeout_s) begin
               err_nxt_s   = 1'b1;
               code_nxt_s  = ERR_CAL_TO;
               state_nxt_s = ST_FAULT;
            end else begin
               state_nxt_s = ST_SREF_EXIT;
            end
         end
         ST_FAULT: begin
            state_nxt_s = ST_FAULT;
         end
         default: begin
            state_nxt_s = ST_FAULT;
         end
      endcase
   end

   // State, outputs and the watchdog counter, which restarts on every state change
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_r     <= ST_IDLE;
         m_r         <= NONE_C;
         req_r       <= NONE_C;
         rest_r      <= NONE_C;
         mig_rst_r   <= ALL_C;
         gate_r      <= 1'b0;
         in_sref_r   <= NONE_C;
         done_r      <= 1'b0;
         err_r       <= 1'b0;
         code_r      <= ERR_NONE;
         cmd_ready_r <= 1'b1;
         busy_r      <= 1'b0;
         cnt_r       <= {CNT_W{1'b0}};
      end else begin
         state_r     <= state_nxt_s;
         m_r         <= m_nxt_s;
         req_r       <= req_nxt_s;
         rest_r      <= rest_nxt_s;
         mig_rst_r   <= rst_nxt_s;
         gate_r      <= gate_nxt_s;
         in_sref_r   <= in_sref_nxt_s;
         done_r      <= done_nxt_s;
         err_r       <= err_nxt_s;
         code_r      <= code_nxt_s;
         cmd_ready_r <= accepts_cmd(state_nxt_s);
         busy_r      <= is_busy(state_nxt_s);
         if (state_nxt_s != state_r) begin
            cnt_r <= {CNT_W{1'b0}};
         end else if (timeout_s) begin
            cnt_r <= cnt_r;
         end else begin
            cnt_r <= cnt_r + CNT_ONE_C;
         end
      end
   end

   assign mig_rst_n       = mig_rst_r;
   assign reset_gate      = gate_r;
   assign ctrl.cmd_ready  = cmd_ready_r;
   assign ctrl.busy       = busy_r;
   assign ctrl.in_sref    = in_sref_r;
   assign ctrl.done_pulse = done_r;
   assign ctrl.err_pulse  = err_r;
   assign ctrl.err_code   = code_r;
   assign ctrl.state_o    = state_r;
endmodule

// File: tb/tb_ddr_sref_sequencer.sv
// Directed bench for ddr_sref_sequencer: a vector table for single commands plus
// hand-written sequences for enter, exit, timeouts, FAULT/async reset and partial exit.
module tb_ddr_sref_sequencer;
   import ddr_sref_pkg::*;

   localparam int N_CH = 3;

   typedef struct {
      logic        op;
      logic [2:0]  mask;
      logic [3:0]  st;
      logic        err;
      logic [1:0]  code;
      logic [23:0] sref;
      logic [2:0]  mig;
      logic        rdy;
      logic [2:0]  insref;
   } vec_t;

   logic              sys_clk = 1'b0;
   logic              sys_rst_n;
   logic [N_CH-1:0]   ack_v;
   logic [N_CH-1:0]   cal_v;
   logic [8*N_CH-1:0] sref_ctrl_in;
   logic [8*N_CH-1:0] sref_ctrl_out;
   logic [N_CH-1:0]   mig_rst_n;
   logic              reset_gate;

   int errors    = 0;
   int checks    = 0;
   int done_cnt  = 0;
   int err_cnt   = 0;

   vec_t vecs [0:3];

   ddr_sref_sequencer_if #(.N_CH(N_CH)) ctrl_if ();

   ddr_sref_sequencer #(
      .N_CH            (N_CH),
      .RST_HOLD_CYCLES (16),
      .TIMEOUT_CYCLES  (100),
      .CNT_W           (20)
   ) dut (
      .sys_clk       (sys_clk),
      .sys_rst_n     (sys_rst_n),
      .ctrl          (ctrl_if.slave),
      .sref_ctrl_in  (sref_ctrl_in),
      .sref_ctrl_out (sref_ctrl_out),
      .mig_rst_n     (mig_rst_n),
      .reset_gate    (reset_gate)
   );

   always #5 sys_clk = ~sys_clk;

   // Ignored status bits carry a junk pattern
   for (genvar i = 0; i < N_CH; i++) begin : g_in
      assign sref_ctrl_in[8*i +: 8] = {6'b101010, cal_v[i], ack_v[i]};
   end

   always @(negedge sys_clk) begin
      if (ctrl_if.done_pulse === 1'b1) done_cnt = done_cnt + 1;
      if (ctrl_if.err_pulse === 1'b1)  err_cnt  = err_cnt + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic nstep();
      @(negedge sys_clk);
      #1;
   endtask

   task automatic issue(input logic op, input logic [2:0] mask);
      @(posedge sys_clk);
      #1;
      ctrl_if.cmd_valid = 1'b1;
      ctrl_if.cmd_op    = op;
      ctrl_if.cmd_mask  = mask;
      @(posedge sys_clk);
      #1;
      ctrl_if.cmd_valid = 1'b0;
      nstep();
   endtask

   task automatic wait_state(input logic [3:0] st, input int max_cyc, input string name);
      int n = 0;
      while ((ctrl_if.state_o !== st) && (n < max_cyc)) begin
         nstep();
         n++;
      end
      chk(name, 32'(ctrl_if.state_o), 32'(st));
   endtask

   task automatic apply_vec(input vec_t v, input int idx);
      string t;
      t = $sformatf("vec%0d", idx);
      issue(v.op, v.mask);
      chk({t, "_state"},  32'(ctrl_if.state_o),   32'(v.st));
      chk({t, "_errp"},   32'(ctrl_if.err_pulse), 32'(v.err));
      chk({t, "_code"},   32'(ctrl_if.err_code),  32'(v.code));
      chk({t, "_sref"},   32'(sref_ctrl_out),     32'(v.sref));
      chk({t, "_mig"},    32'(mig_rst_n),         32'(v.mig));
      chk({t, "_ready"},  32'(ctrl_if.cmd_ready), 32'(v.rdy));
      chk({t, "_insref"}, 32'(ctrl_if.in_sref),   32'(v.insref));
   endtask

   task automatic chk_reset_values(input string t);
      chk({t, "_state"}, 32'(ctrl_if.state_o),    32'(ST_IDLE));
      chk({t, "_sref"},  32'(sref_ctrl_out),      32'h0);
      chk({t, "_mig"},   32'(mig_rst_n),          32'h7);
      chk({t, "_gate"},  32'(reset_gate),         32'h0);
      chk({t, "_ready"}, 32'(ctrl_if.cmd_ready),  32'h1);
      chk({t, "_busy"},  32'(ctrl_if.busy),       32'h0);
      chk({t, "_insref"},32'(ctrl_if.in_sref),    32'h0);
      chk({t, "_done"},  32'(ctrl_if.done_pulse), 32'h0);
      chk({t, "_errp"},  32'(ctrl_if.err_pulse),  32'h0);
      chk({t, "_code"},  32'(ctrl_if.err_code),   32'h0);
   endtask

   initial begin
      int n;
      int bad;
      int d0;
      int e0;

      vecs[0] = '{op:OP_EXIT,  mask:3'b111, st:ST_IDLE,      err:1'b1, code:ERR_ILLEGAL,
                  sref:24'h000000, mig:3'b111, rdy:1'b1, insref:3'b000};
      vecs[1] = '{op:OP_ENTER, mask:3'b000, st:ST_IDLE,      err:1'b1, code:ERR_ILLEGAL,
                  sref:24'h000000, mig:3'b111, rdy:1'b1, insref:3'b000};
      vecs[2] = '{op:OP_ENTER, mask:3'b101, st:ST_ENTER_REQ, err:1'b0, code:ERR_NONE,
                  sref:24'h010001, mig:3'b111, rdy:1'b0, insref:3'b000};
      vecs[3] = '{op:OP_ENTER, mask:3'b111, st:ST_PARKED,    err:1'b1, code:ERR_ILLEGAL,
                  sref:24'h010001, mig:3'b010, rdy:1'b1, insref:3'b101};

      sys_rst_n         = 1'b0;
      ack_v             = 3'b000;
      cal_v             = 3'b000;
      ctrl_if.cmd_valid = 1'b0;
      ctrl_if.cmd_op    = 1'b0;
      ctrl_if.cmd_mask  = 3'b000;
      #22;
      chk_reset_values("rst_held");
      @(negedge sys_clk);
      #1;
      sys_rst_n = 1'b1;
      nstep();
      chk_reset_values("rst_rel");

      // EXIT in IDLE, ENTER with empty mask, then a legal ENTER 101
      e0 = err_cnt;
      for (int i = 0; i < 3; i++) begin
         apply_vec(vecs[i], i);
      end
      chk("illegal_idle_errcnt", 32'(err_cnt - e0), 32'd2);

      // Enter: acks arrive 10 cycles later, then a 16-cycle reset hold
      d0 = done_cnt;
      repeat (10) nstep();
      chk("enter_wait_ack", 32'(ctrl_if.state_o), 32'(ST_ENTER_REQ));
      ack_v = 3'b101;
      wait_state(ST_GATE, 10, "enter_gate");
      chk("gate_on",  32'(reset_gate), 32'h1);
      chk("gate_mig", 32'(mig_rst_n),  32'h2);
      n   = 1;
      bad = 0;
      for (int k = 0; k < 40; k++) begin
         nstep();
         if (ctrl_if.state_o !== ST_GATE) break;
         n++;
         if ((mig_rst_n !== 3'b010) || (reset_gate !== 1'b1)) bad++;
      end
      chk("gate_len",      32'(n),   32'd16);
      chk("gate_stable",   32'(bad), 32'd0);
      chk("park_state",    32'(ctrl_if.state_o),    32'(ST_PARKED));
      chk("park_insref",   32'(ctrl_if.in_sref),    32'h5);
      chk("park_donep",    32'(ctrl_if.done_pulse), 32'h1);
      chk("park_ready",    32'(ctrl_if.cmd_ready),  32'h1);
      chk("park_busy",     32'(ctrl_if.busy),       32'h0);
      chk("park_sref",     32'(sref_ctrl_out),      32'h010001);
      nstep();
      chk("park_donecnt",  32'(done_cnt - d0),      32'd1);

      apply_vec(vecs[3], 3);

      // Exit all: only the parked channels 0/2 are restored
      d0 = done_cnt;
      issue(OP_EXIT, 3'b111);
      chk("rel_state", 32'(ctrl_if.state_o),  32'(ST_RELEASE));
      chk("rel_sref",  32'(sref_ctrl_out),    32'h030003);
      chk("rel_mig",   32'(mig_rst_n),        32'h7);
      chk("rel_gate",  32'(reset_gate),       32'h1);
      chk("rel_code",  32'(ctrl_if.err_code), 32'h0);
      chk("rel_busy",  32'(ctrl_if.busy),     32'h1);
      nstep();
      chk("wcal_state", 32'(ctrl_if.state_o), 32'(ST_WAIT_CAL));
      chk("wcal_gate",  32'(reset_gate),      32'h0);
      repeat (48) nstep();
      chk("wcal_hold",  32'(ctrl_if.state_o), 32'(ST_WAIT_CAL));
      cal_v = 3'b101;
      wait_state(ST_SREF_EXIT, 10, "sexit_state");
      chk("sexit_sref", 32'(sref_ctrl_out), 32'h0);
      ack_v = 3'b000;
      wait_state(ST_IDLE, 10, "exit_idle");
      chk("exit_insref",  32'(ctrl_if.in_sref),   32'h0);
      chk("exit_sref",    32'(sref_ctrl_out),     32'h0);
      chk("exit_mig",     32'(mig_rst_n),         32'h7);
      chk("exit_ready",   32'(ctrl_if.cmd_ready), 32'h1);
      chk("exit_donecnt", 32'(done_cnt - d0),     32'd1);
      cal_v = 3'b000;

      // Enter timeout: ack never comes
      e0 = err_cnt;
      issue(OP_ENTER, 3'b001);
      chk("eto_req", 32'(sref_ctrl_out), 32'h000001);
      n = 0;
      for (int k = 0; k < 200; k++) begin
         if (ctrl_if.err_pulse === 1'b1) break;
         nstep();
         n++;
      end
      chk("eto_latency",  32'((n >= 100) && (n <= 102)), 32'h1);
      chk("eto_code",     32'(ctrl_if.err_code),  32'(ERR_ENTER_TO));
      chk("eto_state",    32'(ctrl_if.state_o),   32'(ST_IDLE));
      chk("eto_sref",     32'(sref_ctrl_out),     32'h0);
      chk("eto_mig",      32'(mig_rst_n),         32'h7);
      chk("eto_errcnt",   32'(err_cnt - e0),      32'd1);

      // Calibration timeout: channel 1 never calibrates
      issue(OP_ENTER, 3'b111);
      ack_v = 3'b111;
      wait_state(ST_PARKED, 40, "cto_park");
      chk("cto_insref", 32'(ctrl_if.in_sref), 32'h7);
      e0 = err_cnt;
      issue(OP_EXIT, 3'b111);
      cal_v = 3'b101;
      wait_state(ST_FAULT, 200, "cto_fault");
      chk("cto_code",   32'(ctrl_if.err_code),  32'(ERR_CAL_TO));
      chk("cto_ready",  32'(ctrl_if.cmd_ready), 32'h0);
      chk("cto_busy",   32'(ctrl_if.busy),      32'h0);
      chk("cto_errcnt", 32'(err_cnt - e0),      32'd1);
      issue(OP_ENTER, 3'b001);
      repeat (4) nstep();
      chk("fault_state", 32'(ctrl_if.state_o), 32'(ST_FAULT));
      chk("fault_sref",  32'(sref_ctrl_out),   32'h030303);
      chk("fault_mig",   32'(mig_rst_n),       32'h7);
      chk("fault_code",  32'(ctrl_if.err_code),32'(ERR_CAL_TO));
      @(negedge sys_clk);
      #1;
      sys_rst_n = 1'b0;
      #2;
      chk_reset_values("async_rst");
      ack_v = 3'b000;
      cal_v = 3'b000;
      @(negedge sys_clk);
      #1;
      sys_rst_n = 1'b1;

      // Partial exit: park all three, release channel 1 only
      issue(OP_ENTER, 3'b111);
      ack_v = 3'b111;
      wait_state(ST_PARKED, 40, "pex_park");
      d0 = done_cnt;
      issue(OP_EXIT, 3'b010);
      chk("pex_rel_state", 32'(ctrl_if.state_o), 32'(ST_RELEASE));
      chk("pex_rel_mig",   32'(mig_rst_n),       32'h2);
      chk("pex_rel_sref",  32'(sref_ctrl_out),   32'h010301);
      cal_v = 3'b010;
      wait_state(ST_SREF_EXIT, 10, "pex_sexit");
      chk("pex_sexit_sref", 32'(sref_ctrl_out), 32'h010001);
      ack_v = 3'b101;
      wait_state(ST_PARKED, 10, "pex_done");
      chk("pex_insref",  32'(ctrl_if.in_sref),   32'h5);
      chk("pex_ready",   32'(ctrl_if.cmd_ready), 32'h1);
      chk("pex_busy",    32'(ctrl_if.busy),      32'h0);
      chk("pex_mig",     32'(mig_rst_n),         32'h2);
      chk("pex_sref",    32'(sref_ctrl_out),     32'h010001);
      chk("pex_donecnt", 32'(done_cnt - d0),     32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
